// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin N-port arbiter in front of a single-port memory.
// One granted port is served at a time. Its command is latched at grant so
// the downstream bus stays stable until mem_resp, whatever the port does.
//
//   state | meaning
//   IDLE  | no transaction in flight; scanning for the next requester
//   BUSY  | latched command driven downstream; waiting for mem_resp
module mem_arbiter #(
    parameter int NUM_PORTS  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    localparam int GRANT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1,
    localparam int BE_W      = DATA_WIDTH / 8
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_PORTS-1:0]                  port_read,
    input  logic [NUM_PORTS-1:0]                  port_write,
    input  logic [NUM_PORTS-1:0][BE_W-1:0]        port_byte_enable,
    input  logic [NUM_PORTS-1:0][ADDR_WIDTH-1:0]  port_address,
    input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]  port_wdata,
    output logic [NUM_PORTS-1:0]                  port_resp,
    output logic [DATA_WIDTH-1:0]                 port_rdata,
    output logic                                  mem_read,
    output logic                                  mem_write,
    output logic [BE_W-1:0]                       mem_byte_enable,
    output logic [ADDR_WIDTH-1:0]                 mem_address,
    output logic [DATA_WIDTH-1:0]                 mem_wdata,
    input  logic                                  mem_resp,
    input  logic [DATA_WIDTH-1:0]                 mem_rdata,
    output logic [GRANT_W-1:0]                    grant,
    output logic                                  busy
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // port 0 wins the first arbitration after reset
    localparam logic [GRANT_W-1:0] LAST_RST = GRANT_W'(NUM_PORTS - 1);

    state_t                  state_q, state_d;
    logic [GRANT_W-1:0]      last_q, last_d;
    logic [GRANT_W-1:0]      grant_q, grant_d;
    logic                    rd_q, rd_d;
    logic                    wr_q, wr_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]         be_q, be_d;

    logic                    found;
    logic [GRANT_W-1:0]      sel;
    logic [GRANT_W-1:0]      idx;

    // state and latched command registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= LAST_RST;
            grant_q <= '0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
        end
    end

    // round-robin pick starting after the last served port, and next state
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        grant_d = grant_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        found   = 1'b0;
        sel     = '0;
        idx     = '0;

        for (int k = 0; k < NUM_PORTS; k++) begin
            idx = GRANT_W'((int'(last_q) + 1 + k) % NUM_PORTS);
            if (!found && (port_read[idx] || port_write[idx])) begin
                found = 1'b1;
                sel   = idx;
            end
        end

        case (state_q)
            IDLE: begin
                if (found) begin
                    state_d = BUSY;
                    grant_d = sel;
                    // read beats write if a port illegally asserts both
                    rd_d    = port_read[sel];
                    wr_d    = !port_read[sel] && port_write[sel];
                    addr_d  = port_address[sel];
                    wdata_d = port_wdata[sel];
                    be_d    = port_read[sel] ? {BE_W{1'b1}} : port_byte_enable[sel];
                end
            end
            BUSY: begin
                if (mem_resp) begin
                    state_d = IDLE;
                    last_d  = grant_q;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                    addr_d  = '0;
                    wdata_d = '0;
                    be_d    = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // completion is routed only to the granted port, and only while busy
    always_comb begin
        port_resp = '0;
        if (state_q == BUSY && mem_resp) begin
            port_resp[grant_q] = 1'b1;
        end
    end

    assign port_rdata      = mem_rdata;
    assign mem_read        = rd_q;
    assign mem_write       = wr_q;
    assign mem_address     = addr_q;
    assign mem_wdata       = wdata_q;
    assign mem_byte_enable = be_q;
    assign grant           = grant_q;
    assign busy            = (state_q == BUSY);

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter (4 ports): requester driver, memory model and a
// scoreboard monitor that checks every port_resp against queued expectations.
module tb_mem_arbiter;

    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     port_read;
    logic [NP-1:0]     port_write;
    logic [NP-1:0][3:0]  port_byte_enable;
    logic [NP-1:0][31:0] port_address;
    logic [NP-1:0][31:0] port_wdata;
    logic [NP-1:0]     port_resp;
    logic [31:0]       port_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [3:0]        mem_byte_enable;
    logic [31:0]       mem_address;
    logic [31:0]       mem_wdata;
    logic              mem_resp;
    logic [31:0]       mem_rdata;
    logic [1:0]        grant;
    logic              busy;

    mem_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .port_read(port_read), .port_write(port_write),
        .port_byte_enable(port_byte_enable), .port_address(port_address),
        .port_wdata(port_wdata), .port_resp(port_resp), .port_rdata(port_rdata),
        .mem_read(mem_read), .mem_write(mem_write),
        .mem_byte_enable(mem_byte_enable), .mem_address(mem_address),
        .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          port;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] alt_addr;
        int          alt_after;
    } cmd_t;

    typedef struct {
        int          port;
        logic        rd;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [31:0] rdata;
    } exp_t;

    cmd_t cq[$];
    exp_t sb[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mem_lat = 1;
    bit mem_en = 1'b1;
    int spur_req = 0;
    int flush_req = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] rd_fn(input logic [31:0] a);
        if (a == 32'h0000_0040) return 32'hDEAD_BEEF;
        return a * 32'd3 + 32'h1111;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic issue(input int p, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [31:0] alt_addr,
                         input int alt_after, input bit push_exp);
        cmd_t c;
        exp_t e;
        c.port = p; c.rd = rd; c.wr = wr; c.addr = addr; c.wdata = wdata;
        c.be = be; c.alt_addr = alt_addr; c.alt_after = alt_after;
        cq.push_back(c);
        if (push_exp) begin
            e.port  = p;
            e.rd    = rd;
            e.wr    = wr && !rd;
            e.addr  = addr;
            e.wdata = wdata;
            e.be    = e.wr ? be : 4'hF;
            e.rdata = rd_fn(addr);
            sb.push_back(e);
        end
    endtask

    // requester driver: holds each request until its port_resp, then moves on
    initial begin : driver
        logic [NP-1:0] snap;
        bit   act[NP];
        int   age[NP];
        cmd_t cur[NP];
        int   flush_done = 0;
        bit   got;
        port_read = '0; port_write = '0; port_byte_enable = '0;
        port_address = '0; port_wdata = '0;
        for (int p = 0; p < NP; p++) begin act[p] = 1'b0; age[p] = 0; end
        forever begin
            @(negedge clk);
            snap = port_resp;
            @(posedge clk);
            #1;
            if (flush_req != flush_done) begin
                flush_done = flush_req;
                cq.delete();
                for (int p = 0; p < NP; p++) act[p] = 1'b0;
                port_read = '0;
                port_write = '0;
            end else begin
                for (int p = 0; p < NP; p++) begin
                    if (act[p]) begin
                        if (snap[p]) act[p] = 1'b0;
                        else begin
                            age[p]++;
                            if (cur[p].alt_after != 0 && age[p] == cur[p].alt_after)
                                port_address[p] = cur[p].alt_addr;
                        end
                    end
                    if (!act[p]) begin
                        got = 1'b0;
                        for (int j = 0; j < cq.size(); j++) begin
                            if (!got && cq[j].port == p) begin
                                got = 1'b1;
                                cur[p] = cq[j];
                                cq.delete(j);
                            end
                        end
                        if (got) begin
                            act[p] = 1'b1;
                            age[p] = 0;
                            port_read[p]        = cur[p].rd;
                            port_write[p]       = cur[p].wr;
                            port_address[p]     = cur[p].addr;
                            port_wdata[p]       = cur[p].wdata;
                            port_byte_enable[p] = cur[p].be;
                        end else begin
                            port_read[p]  = 1'b0;
                            port_write[p] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // memory model: responds mem_lat cycles after a command appears
    initial begin : memory
        int cnt = 0;
        int spur_done = 0;
        mem_resp = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (spur_req != spur_done) begin
                spur_done = spur_req;
                @(posedge clk); #1;
                mem_resp = 1'b1;
                mem_rdata = 32'hBAD0_BAD0;
                @(posedge clk); #1;
                mem_resp = 1'b0;
            end else if (mem_en && (mem_read || mem_write)) begin
                cnt++;
                if (cnt >= mem_lat) begin
                    @(posedge clk); #1;
                    mem_resp = 1'b1;
                    mem_rdata = rd_fn(mem_address);
                    @(posedge clk); #1;
                    mem_resp = 1'b0;
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // scoreboard monitor: every port_resp must match the next expected transaction
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (port_resp != '0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_port_resp", 32'(port_resp), 32'h0);
                end else begin
                    e = sb.pop_front();
                    chk("resp_port", 32'(port_resp), 32'(1) << e.port);
                    chk("resp_grant", 32'(grant), 32'(e.port));
                    chk("resp_busy", 32'(busy), 32'h1);
                    chk("resp_rdata", port_rdata, e.rdata);
                    chk("resp_mem_read", 32'(mem_read), 32'(e.rd));
                    chk("resp_mem_write", 32'(mem_write), 32'(e.wr));
                    chk("resp_mem_address", mem_address, e.addr);
                    chk("resp_mem_wdata", mem_wdata, e.wdata);
                    chk("resp_mem_be", 32'(mem_byte_enable), 32'(e.be));
                end
            end
        end
    end

    task automatic drain(input string nm);
        for (int k = 0; k < 400 && (sb.size() != 0 || cq.size() != 0); k++) @(negedge clk);
        chk(nm, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_idle_outputs(input string nm);
        chk({nm, "_mem_read"}, 32'(mem_read), 0);
        chk({nm, "_mem_write"}, 32'(mem_write), 0);
        chk({nm, "_mem_address"}, mem_address, 0);
        chk({nm, "_mem_wdata"}, mem_wdata, 0);
        chk({nm, "_mem_be"}, 32'(mem_byte_enable), 0);
        chk({nm, "_port_resp"}, 32'(port_resp), 0);
        chk({nm, "_grant"}, 32'(grant), 0);
        chk({nm, "_busy"}, 32'(busy), 0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int c0;
        repeat (2) @(negedge clk);
        check_idle_outputs("in_reset");
        rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("after_reset");

        // single read, 3-cycle memory, exact cycle placement
        mem_lat = 3;
        issue(0, 1, 0, 32'h40, 32'h0, 4'h0, 32'h0, 0, 1);
        for (int k = 0; k < 20 && port_read[0] !== 1'b1; k++) @(negedge clk);
        chk("t1_req_seen", 32'(port_read[0]), 1);
        chk("t1_no_cmd_yet", 32'(mem_read), 0);
        @(negedge clk);
        chk("t1_mem_read", 32'(mem_read), 1);
        chk("t1_mem_address", mem_address, 32'h40);
        chk("t1_grant", 32'(grant), 0);
        chk("t1_busy", 32'(busy), 1);
        c0 = cyc;
        for (int k = 0; k < 20 && mem_resp !== 1'b1; k++) @(negedge clk);
        chk("t1_resp_latency", cyc - c0, 3);
        @(negedge clk);
        chk("t1_read_dropped", 32'(mem_read), 0);
        chk("t1_busy_dropped", 32'(busy), 0);
        drain("t1_drain");

        // minimum latency with a 1-cycle memory
        mem_lat = 1;
        issue(1, 1, 0, 32'h44, 32'h0, 4'h0, 32'h0, 0, 1);
        for (int k = 0; k < 20 && port_read[1] !== 1'b1; k++) @(negedge clk);
        c0 = cyc;
        for (int k = 0; k < 20 && port_resp[1] !== 1'b1; k++) @(negedge clk);
        chk("t2_min_latency", cyc - c0, 2);
        drain("t2_drain");

        // simultaneous requests from reset, turnaround of one dead cycle
        pulse_reset();
        issue(0, 1, 0, 32'h100, 32'h0, 4'h0, 32'h0, 0, 1);
        issue(1, 0, 1, 32'h200, 32'h1234_5678, 4'b0011, 32'h0, 0, 1);
        for (int k = 0; k < 20 && port_resp[0] !== 1'b1; k++) @(negedge clk);
        c0 = cyc;
        for (int k = 0; k < 20 && mem_write !== 1'b1; k++) @(negedge clk);
        chk("t3_turnaround", cyc - c0, 2);
        chk("t3_grant_second", 32'(grant), 1);
        drain("t3_drain");

        // four ports continuously requesting, two commands each
        pulse_reset();
        mem_lat = 2;
        for (int r = 0; r < 2; r++)
            for (int p = 0; p < NP; p++)
                issue(p, (p % 2) == 0, (p % 2) == 1, 32'h1000 + 32'(16 * (r * NP + p)),
                      32'hA000_0000 + 32'(p), 4'(p + 1), 32'h0, 0, 1);
        drain("t4_drain");

        // illegal read+write on one port: read wins
        mem_lat = 1;
        issue(2, 1, 1, 32'h500, 32'hFFFF_0000, 4'h5, 32'h0, 0, 1);
        drain("t5_drain");

        // granted port changes address mid-transaction
        mem_lat = 4;
        issue(3, 1, 0, 32'h40, 32'h0, 4'h0, 32'h80, 2, 1);
        for (int k = 0; k < 20 && port_address[3] !== 32'h80; k++) @(negedge clk);
        chk("t6_addr_changed", port_address[3], 32'h80);
        chk("t6_mem_addr_held", mem_address, 32'h40);
        chk("t6_busy", 32'(busy), 1);
        drain("t6_drain");

        // spurious mem_resp while idle
        spur_req++;
        for (int k = 0; k < 20 && mem_resp !== 1'b1; k++) @(negedge clk);
        chk("t7_spur_seen", 32'(mem_resp), 1);
        chk("t7_spur_no_resp", 32'(port_resp), 0);
        chk("t7_spur_busy", 32'(busy), 0);
        @(negedge clk);
        chk("t7_after_busy", 32'(busy), 0);

        // reset while busy, then a late mem_resp
        mem_en = 1'b0;
        issue(0, 1, 0, 32'h300, 32'h0, 4'h0, 32'h0, 0, 0);
        for (int k = 0; k < 20 && mem_read !== 1'b1; k++) @(negedge clk);
        chk("t8_busy_before_rst", 32'(busy), 1);
        flush_req++;
        @(posedge clk); #2;
        chk("t8_still_reading", 32'(mem_read), 1);
        rst = 1'b1;
        #1;
        check_idle_outputs("t8_on_rst");
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        spur_req++;
        for (int k = 0; k < 20 && mem_resp !== 1'b1; k++) @(negedge clk);
        chk("t8_late_resp_seen", 32'(mem_resp), 1);
        chk("t8_late_no_resp", 32'(port_resp), 0);
        chk("t8_late_busy", 32'(busy), 0);
        repeat (3) @(negedge clk);
        chk("t8_stays_idle", 32'(busy), 0);
        chk("t8_no_read", 32'(mem_read), 0);
        mem_en = 1'b1;

        chk("final_scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
